// File: rtl/mem_arbiter.sv
// Round-robin arbiter for icache/dcache line bursts onto one shared memory port.
// Owns request issue, write-beat streaming and read-beat routing back to the owner.
module mem_arbiter #(
    parameter int unsigned BEATS  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ic_req_valid,
    output logic              ic_req_ready,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_resp_valid,
    output logic              ic_resp_last,
    output logic [31:0]       ic_resp_data,

    input  logic              dc_req_valid,
    output logic              dc_req_ready,
    input  logic              dc_req_we,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic              dc_wdata_valid,
    output logic              dc_wdata_ready,
    input  logic [31:0]       dc_wdata,
    output logic              dc_resp_valid,
    output logic              dc_resp_last,
    output logic [31:0]       dc_resp_data,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_wdata_valid,
    input  logic              mem_wdata_ready,
    output logic [31:0]       mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data
);

    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam int unsigned OFF_W = $clog2(BEATS * 4);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WDATA,
        ST_RDATA
    } state_e;

    state_e            state_q;
    logic              owner_q;
    logic              we_q;
    logic              last_grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  beat_cnt_q;

    logic              in_idle;
    logic              in_req;
    logic              in_wdata;
    logic              in_rdata;
    logic              gnt_d;
    logic              req_hs;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] addr_d;
    logic              wdata_hs;
    logic              rbeat;
    logic              at_last;

    assign in_idle  = (state_q == ST_IDLE);
    assign in_req   = (state_q == ST_REQ);
    assign in_wdata = (state_q == ST_WDATA);
    assign in_rdata = (state_q == ST_RDATA);

    // Winner among current requesters: on a tie, whoever was not granted last.
    always_comb begin
        gnt_d = 1'b0;
        if (ic_req_valid && dc_req_valid) begin
            gnt_d = ~last_grant_q;
        end else if (dc_req_valid) begin
            gnt_d = 1'b1;
        end
    end

    assign req_hs       = in_idle && (ic_req_valid || dc_req_valid);
    assign ic_req_ready = in_idle && ic_req_valid && !gnt_d;
    assign dc_req_ready = in_idle && dc_req_valid && gnt_d;
    assign req_addr     = gnt_d ? dc_req_addr : ic_req_addr;
    assign addr_d       = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    assign wdata_hs = in_wdata && dc_wdata_valid && mem_wdata_ready;
    assign rbeat    = in_rdata && mem_resp_valid;
    assign at_last  = (beat_cnt_q == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            last_grant_q <= 1'b0;
            addr_q       <= '0;
            beat_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_hs) begin
                        owner_q      <= gnt_d;
                        we_q         <= gnt_d & dc_req_we;
                        addr_q       <= addr_d;
                        last_grant_q <= gnt_d;
                        state_q      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        beat_cnt_q <= '0;
                        state_q    <= we_q ? ST_WDATA : ST_RDATA;
                    end
                end
                ST_WDATA: begin
                    if (wdata_hs) begin
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        if (at_last) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_RDATA: begin
                    if (rbeat) begin
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        if (at_last) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Memory-side request and write streaming; everything gated to 0 when inactive.
    assign mem_req_valid   = in_req;
    assign mem_req_we      = in_req & we_q;
    assign mem_req_addr    = in_req ? addr_q : '0;
    assign mem_wdata_valid = in_wdata & dc_wdata_valid;
    assign dc_wdata_ready  = in_wdata & mem_wdata_ready;
    assign mem_wdata       = in_wdata ? dc_wdata : '0;

    // Read beats go only to the owner; data follows the gated valid.
    assign ic_resp_valid = rbeat & ~owner_q;
    assign dc_resp_valid = rbeat & owner_q;
    assign ic_resp_last  = ic_resp_valid & at_last;
    assign dc_resp_last  = dc_resp_valid & at_last;
    assign ic_resp_data  = ic_resp_valid ? mem_resp_data : '0;
    assign dc_resp_data  = dc_resp_valid ? mem_resp_data : '0;

endmodule
